// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: EX/MEM register, branch resolution and the data-memory req/ack access FSM.
// Optional build macro DM_TIMEOUT_EN adds an ack-wait watchdog with a sticky err_M output.
module mem_stage_lsu #(
   parameter int N       = 64,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_E,
   input  logic [N-1:0] aluResult_E,
   input  logic [N-1:0] writeData_E,
   input  logic [N-1:0] PCBranch_E,
   input  logic         zero_E,
   input  logic         Branch_E,
   input  logic         MemRead_E,
   input  logic         MemWrite_E,
   input  logic         RegWrite_E,
   input  logic         MemtoReg_E,
   input  logic [4:0]   rd_E,
   output logic         stall_M,
   output logic         PCSrc_M,
   output logic [N-1:0] PCBranch_M,
   output logic         dm_req,
   output logic         dm_we,
   output logic [N-1:0] dm_addr,
   output logic [N-1:0] dm_wdata,
   input  logic         dm_ack,
   input  logic [N-1:0] dm_rdata,
   output logic         valid_M,
   output logic [N-1:0] readData_M,
   output logic [N-1:0] aluResult_M,
   output logic [4:0]   rd_M,
   output logic         RegWrite_M,
   output logic         MemtoReg_M
`ifdef DM_TIMEOUT_EN
   ,
   output logic         err_M
`endif
);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t       state, state_nxt;
   logic         Branch_M, MemRead_M, MemWrite_M, zero_M;
   logic         reg_write_q, memto_reg_q;
   logic         done;
   logic [N-1:0] writeData_M;
   logic [N-1:0] rdata_q;
   logic         load_en;
   logic         memop_E;
   logic         ack_hit;
   logic         timeout_hit;
   logic         is_load_M;

   // Only a surviving (not squashed) memory instruction starts an access.
   assign memop_E   = valid_E & ~PCSrc_M & (MemRead_E | MemWrite_E);
   assign is_load_M = MemRead_M & ~MemWrite_M;
   assign PCSrc_M   = valid_M & Branch_M & zero_M;

   assign dm_we      = MemWrite_M;
   assign dm_addr    = aluResult_M;
   assign dm_wdata   = writeData_M;
   assign RegWrite_M = valid_M & reg_write_q;
   assign MemtoReg_M = valid_M & memto_reg_q;

`ifdef DM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   assign timeout_hit = (state == REQ) & ~dm_ack & (wait_cnt == TO_LAST);
   assign err_M       = err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (load_en)
            wait_cnt <= '0;
         else if ((state == REQ) && !dm_ack)
            wait_cnt <= wait_cnt + 1'b1;
         if (timeout_hit)
            err_q <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // REQ is held exactly while the M-stage memop has not completed (memop & ~done).
   always_comb begin
      state_nxt = state;
      dm_req    = 1'b0;
      stall_M   = 1'b0;
      ack_hit   = 1'b0;
      if (state == REQ) begin
         dm_req  = 1'b1;
         ack_hit = dm_ack;
         stall_M = ~dm_ack;
         if (dm_ack || timeout_hit)
            state_nxt = IDLE;
      end
      load_en = ~stall_M;
      if (load_en)
         state_nxt = memop_E ? REQ : IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Load data is forwarded in the ack cycle so a zero-wait access costs no stall.
   always_comb begin
      readData_M = '0;
      if (done)
         readData_M = rdata_q;
      else if (dm_req && dm_ack && is_load_M)
         readData_M = dm_rdata;
   end

   // EX/MEM register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_M     <= 1'b0;
         Branch_M    <= 1'b0;
         MemRead_M   <= 1'b0;
         MemWrite_M  <= 1'b0;
         zero_M      <= 1'b0;
         reg_write_q <= 1'b0;
         memto_reg_q <= 1'b0;
         aluResult_M <= '0;
         writeData_M <= '0;
         PCBranch_M  <= '0;
         rd_M        <= '0;
         done        <= 1'b0;
         rdata_q     <= '0;
      end else begin
         if (load_en) begin
            valid_M     <= valid_E & ~PCSrc_M;
            Branch_M    <= Branch_E;
            MemRead_M   <= MemRead_E;
            MemWrite_M  <= MemWrite_E;
            zero_M      <= zero_E;
            reg_write_q <= RegWrite_E;
            memto_reg_q <= MemtoReg_E;
            aluResult_M <= aluResult_E;
            writeData_M <= writeData_E;
            PCBranch_M  <= PCBranch_E;
            rd_M        <= rd_E;
            done        <= 1'b0;
         end else if (ack_hit || timeout_hit) begin
            done <= 1'b1;
         end
         if (ack_hit)
            rdata_q <= dm_rdata;
         else if (timeout_hit)
            rdata_q <= '0;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu: reset, loads, stores, branches, wait states.
// Define DM_TIMEOUT_EN for both files to also exercise the ack-wait watchdog.
module tb_mem_stage_lsu;
   localparam int N = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         valid_E;
   logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
   logic         zero_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E;
   logic [4:0]   rd_E;
   logic         stall_M, PCSrc_M;
   logic [N-1:0] PCBranch_M;
   logic         dm_req, dm_we;
   logic [N-1:0] dm_addr, dm_wdata;
   logic         dm_ack;
   logic [N-1:0] dm_rdata;
   logic         valid_M;
   logic [N-1:0] readData_M, aluResult_M;
   logic [4:0]   rd_M;
   logic         RegWrite_M, MemtoReg_M;
`ifdef DM_TIMEOUT_EN
   logic         err_M;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   mem_stage_lsu #(.N(N), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .valid_E(valid_E),
      .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
      .zero_E(zero_E), .Branch_E(Branch_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
      .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .rd_E(rd_E),
      .stall_M(stall_M), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .valid_M(valid_M), .readData_M(readData_M), .aluResult_M(aluResult_M),
      .rd_M(rd_M), .RegWrite_M(RegWrite_M), .MemtoReg_M(MemtoReg_M)
`ifdef DM_TIMEOUT_EN
      , .err_M(err_M)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic drive_e(input logic v, input logic [N-1:0] alu, input logic [N-1:0] wd,
                          input logic [N-1:0] pcb, input logic z, input logic br,
                          input logic mr, input logic mw, input logic rw, input logic m2r,
                          input logic [4:0] rd);
      valid_E = v;  aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb;
      zero_E = z;   Branch_E = br;     MemRead_E = mr;   MemWrite_E = mw;
      RegWrite_E = rw; MemtoReg_E = m2r; rd_E = rd;
   endtask

   task automatic idle_e();
      drive_e(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
   endtask

   // Inputs change on the falling edge; outputs are checked 1 time unit later.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b0;
      dm_ack = 1'b0;
      dm_rdata = '0;
      idle_e();
      next_cycle(); next_cycle(); #1;
      check("rst_valid", valid_M, 0);
      check("rst_req", dm_req, 0);
      check("rst_stall", stall_M, 0);
      check("rst_pcsrc", PCSrc_M, 0);
      check("rst_rdata", readData_M, 0);
`ifdef DM_TIMEOUT_EN
      check("rst_err", err_M, 0);
`endif
      next_cycle(); reset = 1'b1;

      // Reset in the middle of an outstanding load.
      next_cycle();
      drive_e(1'b1, 64'h300, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
      next_cycle(); idle_e(); #1;
      check("mid_req_before", dm_req, 1);
      check("mid_stall_before", stall_M, 1);
      #1 reset = 1'b0;
      #1;
      check("mid_req_rst", dm_req, 0);
      check("mid_valid_rst", valid_M, 0);
      check("mid_stall_rst", stall_M, 0);
      check("mid_alu_rst", aluResult_M, 0);
      next_cycle(); reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         next_cycle(); #1;
         check("post_rst_req", dm_req, 0);
         check("post_rst_valid", valid_M, 0);
         check("post_rst_stall", stall_M, 0);
      end

      // Zero-wait load.
      next_cycle();
      drive_e(1'b1, 64'h100, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
      next_cycle(); idle_e(); dm_ack = 1'b1; dm_rdata = 64'hDEADBEEF; #1;
      check("zw_req", dm_req, 1);
      check("zw_we", dm_we, 0);
      check("zw_addr", dm_addr, 64'h100);
      check("zw_stall", stall_M, 0);
      check("zw_rdata", readData_M, 64'hDEADBEEF);
      check("zw_rd", rd_M, 5);
      check("zw_regwrite", RegWrite_M, 1);
      check("zw_memtoreg", MemtoReg_M, 1);
      next_cycle(); dm_ack = 1'b0; dm_rdata = '0; #1;
      check("zw_req_after", dm_req, 0);
      check("zw_valid_after", valid_M, 0);
      check("zw_regwrite_gated", RegWrite_M, 0);
      next_cycle(); #1;
      check("zw_req_after2", dm_req, 0);

      // Store with three wait cycles, younger ALU op waiting behind it.
      next_cycle();
      drive_e(1'b1, 64'h208, 64'h55, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      next_cycle();
      drive_e(1'b1, 64'h77, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) next_cycle();
         #1;
         check("ws_stall", stall_M, 1);
         check("ws_req", dm_req, 1);
         check("ws_we", dm_we, 1);
         check("ws_addr", dm_addr, 64'h208);
         check("ws_wdata", dm_wdata, 64'h55);
         check("ws_hold_alu", aluResult_M, 64'h208);
      end
      next_cycle(); dm_ack = 1'b1; #1;
      check("ws_ack_stall", stall_M, 0);
      check("ws_ack_req", dm_req, 1);
      next_cycle(); dm_ack = 1'b0; idle_e(); #1;
      check("ws_next_valid", valid_M, 1);
      check("ws_next_alu", aluResult_M, 64'h77);
      check("ws_next_rd", rd_M, 7);
      check("ws_next_req", dm_req, 0);
      check("ws_next_stall", stall_M, 0);

      // Taken branch squashes the following store.
      next_cycle();
      drive_e(1'b1, '0, '0, 64'h40, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      next_cycle();
      drive_e(1'b1, 64'h500, 64'h99, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9);
      #1;
      check("br_pcsrc", PCSrc_M, 1);
      check("br_target", PCBranch_M, 64'h40);
      check("br_stall", stall_M, 0);
      check("br_req", dm_req, 0);
      next_cycle(); idle_e(); #1;
      check("sq_valid", valid_M, 0);
      check("sq_req", dm_req, 0);
      check("sq_pcsrc", PCSrc_M, 0);
      check("sq_regwrite", RegWrite_M, 0);
      next_cycle(); #1;
      check("sq_req2", dm_req, 0);

      // Not-taken branch, then loads with ack delays 0, 2, 0.
      next_cycle();
      drive_e(1'b1, '0, '0, 64'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      next_cycle();
      drive_e(1'b1, 64'h110, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1);
      #1;
      check("nt_pcsrc", PCSrc_M, 0);
      check("nt_valid", valid_M, 1);
      next_cycle();
      drive_e(1'b1, 64'h118, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
      dm_ack = 1'b1; dm_rdata = 64'h1111; #1;
      check("la_req", dm_req, 1);
      check("la_addr", dm_addr, 64'h110);
      check("la_rdata", readData_M, 64'h1111);
      check("la_stall", stall_M, 0);
      check("la_rd", rd_M, 1);
      next_cycle(); idle_e(); dm_ack = 1'b0; dm_rdata = 64'hBAD0; #1;
      check("lb_req", dm_req, 1);
      check("lb_addr", dm_addr, 64'h118);
      check("lb_stall1", stall_M, 1);
      check("lb_rdata_wait", readData_M, 0);
      check("lb_rd", rd_M, 2);
      next_cycle(); #1;
      check("lb_stall2", stall_M, 1);
      next_cycle();
      drive_e(1'b1, 64'h120, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
      dm_ack = 1'b1; dm_rdata = 64'h2222; #1;
      check("lb_rdata", readData_M, 64'h2222);
      check("lb_stall_ack", stall_M, 0);
      next_cycle(); idle_e(); dm_ack = 1'b1; dm_rdata = 64'h3333; #1;
      check("lc_addr", dm_addr, 64'h120);
      check("lc_rdata", readData_M, 64'h3333);
      check("lc_stall", stall_M, 0);
      next_cycle(); dm_ack = 1'b0; dm_rdata = '0; #1;
      check("lc_req_after", dm_req, 0);
      check("lc_rdata_after", readData_M, 0);

      // MemRead and MemWrite both set: behaves as a store, no load data returned.
      next_cycle();
      drive_e(1'b1, 64'h600, 64'hAB, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
      next_cycle(); idle_e(); dm_ack = 1'b1; dm_rdata = 64'h77; #1;
      check("rw_we", dm_we, 1);
      check("rw_wdata", dm_wdata, 64'hAB);
      check("rw_rdata", readData_M, 0);
      next_cycle(); dm_ack = 1'b0; dm_rdata = '0; #1;
      check("rw_req_after", dm_req, 0);

`ifdef DM_TIMEOUT_EN
      // Load that never gets an ack: watchdog aborts after 16 request cycles.
      next_cycle();
      drive_e(1'b1, 64'h700, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
      next_cycle(); idle_e(); dm_rdata = 64'hFFFF;
      for (int i = 0; i < 16; i++) begin
         if (i > 0) next_cycle();
         #1;
         check("to_req", dm_req, 1);
         check("to_stall", stall_M, 1);
      end
      next_cycle(); #1;
      check("to_req_drop", dm_req, 0);
      check("to_err", err_M, 1);
      check("to_rdata", readData_M, 0);
      check("to_stall_drop", stall_M, 0);
      next_cycle(); #1;
      check("to_err_sticky", err_M, 1);
      check("to_valid_next", valid_M, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
